// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder controller: feeds an external 4-bit ripple-carry slice one nibble
// per clock (LSB first), chains the carry through a flop and collects the sum.
module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [3:0]       add_x,
    output logic [3:0]       add_y,
    output logic             add_cy_in,
    input  logic [3:0]       add_s,
    input  logic             add_cy_4,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    // Slice operands only while running; zero otherwise so the slice sees a quiet input.
    always_comb begin
        add_x     = 4'h0;
        add_y     = 4'h0;
        add_cy_in = 1'b0;
        if (state_q == StRun) begin
            add_cy_in = carry_q;
            for (int i = 0; i < int'(NIBBLES); i++) begin
                if (idx_q == IdxW'(i)) begin
                    add_x = a_q[4*i +: 4];
                    add_y = b_q[4*i +: 4];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                for (int i = 0; i < int'(NIBBLES); i++) begin
                    if (idx_q == IdxW'(i)) begin
                        sum_d[4*i +: 4] = add_s;
                    end
                end
                carry_d = add_cy_4;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    cout_d  = add_cy_4;
                    // add_s[3] is the final sum MSB being written this cycle.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_s[3] != a_q[WIDTH-1]);
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: arithmetic reference model plus directed vectors,
// with a behavioural 4-bit slice closing the loop around the DUT.
module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a, b;
    logic          cin;
    logic [3:0]    add_x, add_y, add_s;
    logic          add_cy_in, add_cy_4;
    logic          busy, done, cout, ovf;
    logic [W-1:0]  sum;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .add_x     (add_x),
        .add_y     (add_y),
        .add_cy_in (add_cy_in),
        .add_s     (add_s),
        .add_cy_4  (add_cy_4),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    logic [4:0] slice_res;
    assign slice_res = {1'b0, add_x} + {1'b0, add_y} + {4'b0, add_cy_in};
    assign add_s     = slice_res[3:0];
    assign add_cy_4  = slice_res[4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Returns {ovf, cout, sum} of a full-width addition.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c);
        logic [W:0] t;
        t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        ref_add = {(x[W-1] == y[W-1]) && (t[W-1] != x[W-1]), t[W], t[W-1:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: cycles remaining in an operation, and the published result.
    int           m_cnt  = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_a = '0, m_b = '0, m_sum = '0;
    logic         m_cin = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_done <= 1'b0; m_a <= '0; m_b <= '0; m_cin <= 1'b0;
            m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_done <= 1'b1;
                {m_ovf, m_cout, m_sum} <= ref_add(m_a, m_b, m_cin);
            end else begin
                m_done <= 1'b0;
            end
        end else if (start) begin
            m_a <= a; m_b <= b; m_cin <= cin; m_cnt <= NIB; m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin : cmp
        int k;
        logic [31:0] lm, ex_c;
        chk("busy", 32'(busy), 32'(m_cnt > 0));
        chk("done", 32'(done), 32'(m_done));
        if (m_cnt > 0) begin
            k    = NIB - m_cnt;
            lm   = (32'd1 << (4 * k)) - 32'd1;
            ex_c = ((32'(m_a) & lm) + (32'(m_b) & lm) + 32'(m_cin)) >> (4 * k);
            chk("add_x", 32'(add_x), (32'(m_a) >> (4 * k)) & 32'hF);
            chk("add_y", 32'(add_y), (32'(m_b) >> (4 * k)) & 32'hF);
            chk("add_cy_in", 32'(add_cy_in), ex_c);
        end else begin
            chk("add_x_idle", 32'(add_x), 32'd0);
            chk("add_y_idle", 32'(add_y), 32'd0);
            chk("add_cy_in_idle", 32'(add_cy_in), 32'd0);
            chk("sum", 32'(sum), 32'(m_sum));
            chk("cout", 32'(cout), 32'(m_cout));
            chk("ovf", 32'(ovf), 32'(m_ovf));
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 12) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input logic [W-1:0] es, input logic ec, input logic eo,
                         input string nm);
        int n;
        @(negedge clk);
        a = x; b = y; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
        chk({nm, "_busy"}, 32'(busy), 32'd1);
        wait_done(n);
        chk({nm, "_latency"}, 32'(n), 32'(NIB));
        chk({nm, "_sum"}, 32'(sum), 32'(es));
        chk({nm, "_cout"}, 32'(cout), 32'(ec));
        chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
        @(negedge clk);
        chk({nm, "_done_pulse"}, 32'(done), 32'd0);
        chk({nm, "_sum_held"}, 32'(sum), 32'(es));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, t1, t2, dones;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;

        chk("model_5555", 32'(ref_add(16'h1234, 16'h4321, 1'b0)), 32'h05555);
        chk("model_ripple", 32'(ref_add(16'hFFFF, 16'h0000, 1'b1)), 32'h10000);
        chk("model_ovf_pos", 32'(ref_add(16'h7FFF, 16'h0001, 1'b0)), 32'h28000);
        chk("model_ovf_neg", 32'(ref_add(16'h8000, 16'h8000, 1'b0)), 32'h30000);

        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
        chk("rst_add_xy", 32'({add_x, add_y}), 32'd0);

        do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "basic");
        do_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "ripple");
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_pos");
        do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "ovf_neg");

        // start during RUN must be ignored
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("ignore_done", 32'(done), 32'd1);
        chk("ignore_sum", 32'(sum), 32'h5555);
        @(negedge clk);

        // reset mid-RUN
        a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_add", 32'({add_x, add_y, add_cy_in}), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "after_rst");

        // back-to-back: start held across done
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'h0F0F; b = 16'h0101;
        wait_done(n);
        t1 = cyc;
        chk("b2b_first_sum", 32'(sum), 32'h5555);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_restart_busy", 32'(busy), 32'd1);
        wait_done(n);
        t2 = cyc;
        chk("b2b_spacing", 32'(t2 - t1), 32'(NIB + 1));
        chk("b2b_sum", 32'(sum), 32'h1010);
        chk("b2b_cout_ovf", 32'({cout, ovf}), 32'd0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
